// File: rtl/iecdrv_gcr_stream_if.sv
// Track-memory bus between the GCR stream engine (master) and the track RAM (slave).
// Read data on mem_din follows mem_addr by two clocks.
interface iecdrv_gcr_stream_if #(
    parameter int unsigned ADDRWIDTH = 13
);
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [7:0]           mem_din;
    logic [7:0]           mem_dout;
    logic                 mem_we;

    modport master (
        output mem_addr,
        output mem_dout,
        output mem_we,
        input  mem_din
    );

    modport slave (
        input  mem_addr,
        input  mem_dout,
        input  mem_we,
        output mem_din
    );
endinterface

// File: rtl/iecdrv_gcr_stream.sv
// Disk-drive GCR bit stream engine: walks a circular track memory at zone-dependent
// bit-cell rate, frames read bytes on sync, and writes bytes back in write mode.
module iecdrv_gcr_stream #(
    parameter int unsigned ADDRWIDTH = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 mtr,
    input  logic                 mode,
    input  logic [1:0]           speed_zone,
    input  logic [ADDRWIDTH-1:0] track_len,
    input  logic                 track_change,
    input  logic [7:0]           wr_byte,
    input  logic                 dirty_clr,
    iecdrv_gcr_stream_if.master  mem,
    output logic [7:0]           rd_byte,
    output logic                 byte_ready,
    output logic                 sync,
    output logic                 dirty
);

    localparam logic [1:0] LOAD0 = 2'd0;
    localparam logic [1:0] LOAD1 = 2'd1;
    localparam logic [1:0] LOAD2 = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]           state_q;
    logic [ADDRWIDTH-1:0] byte_addr_q;
    logic [ADDRWIDTH-1:0] mem_addr_q;
    logic [2:0]           bit_idx_q;
    logic [2:0]           frame_cnt_q;
    logic [5:0]           cell_cnt_q;
    logic [3:0]           ones_cnt_q;
    logic [7:0]           cur_byte_q;
    logic [7:0]           shift_q;
    logic [7:0]           wr_shift_q;
    logic [7:0]           mem_dout_q;
    logic                 mode_q;
    logic                 mem_we_q;

    function automatic logic [ADDRWIDTH-1:0] next_addr(input logic [ADDRWIDTH-1:0] a,
                                                       input logic [ADDRWIDTH-1:0] len);
        logic [ADDRWIDTH:0] inc;
        inc = {1'b0, a} + {{ADDRWIDTH{1'b0}}, 1'b1};
        return (inc >= {1'b0, len}) ? '0 : inc[ADDRWIDTH-1:0];
    endfunction

    logic [ADDRWIDTH-1:0] addr_nxt1;
    logic [ADDRWIDTH-1:0] addr_nxt2;
    logic [ADDRWIDTH-1:0] load_addr;
    logic [5:0]           cell_lim;
    logic                 run_en;
    logic                 tick;
    logic                 boundary;
    logic                 cur_bit;
    logic [3:0]           ones_nxt;
    logic                 sync_nxt;

    // cell_lim = (16 - zone) * 4 - 1
    assign cell_lim  = 6'd63 - {2'b00, speed_zone, 2'b00};
    assign addr_nxt1 = next_addr(byte_addr_q, track_len);
    assign addr_nxt2 = next_addr(addr_nxt1, track_len);
    assign load_addr = (byte_addr_q >= track_len) ? '0 : byte_addr_q;
    assign run_en    = (state_q == RUN) && mtr && (track_len >= ADDRWIDTH'(2)) && ce;
    assign tick      = run_en && (cell_cnt_q >= cell_lim);
    assign boundary  = tick && (bit_idx_q == 3'd7);
    assign cur_bit   = cur_byte_q[3'd7 - bit_idx_q];
    assign ones_nxt  = cur_bit ? ((ones_cnt_q == 4'd15) ? 4'd15 : ones_cnt_q + 4'd1) : 4'd0;
    assign sync_nxt  = cur_bit && (ones_nxt >= 4'd10);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD0;
            byte_addr_q <= '0;
            mem_addr_q  <= '0;
            bit_idx_q   <= 3'd0;
            frame_cnt_q <= 3'd0;
            cell_cnt_q  <= 6'd0;
            ones_cnt_q  <= 4'd0;
            cur_byte_q  <= 8'h00;
            shift_q     <= 8'h00;
            wr_shift_q  <= 8'h00;
            mem_dout_q  <= 8'h00;
            mode_q      <= 1'b1;
            mem_we_q    <= 1'b0;
            rd_byte     <= 8'h00;
            byte_ready  <= 1'b0;
            sync        <= 1'b0;
            dirty       <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            mem_we_q   <= 1'b0;
            dirty      <= mem_we_q | (dirty & ~dirty_clr);
            // After a write strobe, point the RAM back at the upcoming byte.
            if (mem_we_q) begin
                mem_addr_q <= addr_nxt1;
            end

            if (track_change) begin
                state_q     <= LOAD0;
                byte_addr_q <= load_addr;
                mem_addr_q  <= load_addr;
            end else begin
                case (state_q)
                    LOAD0: begin
                        mem_addr_q <= byte_addr_q;
                        state_q    <= LOAD1;
                    end
                    LOAD1: state_q <= LOAD2;
                    LOAD2: begin
                        cur_byte_q <= mem.mem_din;
                        mem_addr_q <= addr_nxt1;
                        bit_idx_q  <= 3'd0;
                        mode_q     <= mode;
                        if (!mode) begin
                            wr_shift_q <= wr_byte;
                            byte_ready <= 1'b1;
                        end
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (run_en) begin
                            cell_cnt_q <= tick ? 6'd0 : cell_cnt_q + 6'd1;
                        end
                        if (tick) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (mode_q) begin
                                ones_cnt_q <= ones_nxt;
                                shift_q    <= {shift_q[6:0], cur_bit};
                                sync       <= sync_nxt;
                                // Framing restarts on every sync bit, so bytes align to sync.
                                if (sync_nxt) begin
                                    frame_cnt_q <= 3'd0;
                                end else if (frame_cnt_q == 3'd7) begin
                                    rd_byte     <= {shift_q[6:0], cur_bit};
                                    byte_ready  <= 1'b1;
                                    frame_cnt_q <= 3'd0;
                                end else begin
                                    frame_cnt_q <= frame_cnt_q + 3'd1;
                                end
                            end
                            if (boundary) begin
                                cur_byte_q  <= mem.mem_din;
                                byte_addr_q <= addr_nxt1;
                                mode_q      <= mode;
                                if (mode_q) begin
                                    mem_addr_q <= addr_nxt2;
                                end else begin
                                    mem_we_q   <= 1'b1;
                                    mem_addr_q <= byte_addr_q;
                                    mem_dout_q <= wr_shift_q;
                                end
                                if (!mode) begin
                                    wr_shift_q <= wr_byte;
                                    byte_ready <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= LOAD0;
                endcase
            end
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_dout = mem_dout_q;
    assign mem.mem_we   = mem_we_q;

endmodule

// File: tb/tb_iecdrv_gcr_stream.sv
// Bench for iecdrv_gcr_stream: bit-rate table, sync/framing, write path, reset and reload cases.
module tb_iecdrv_gcr_stream;
    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b1;
    logic          mtr = 1'b1;
    logic          mode = 1'b1;
    logic [1:0]    speed_zone = 2'd3;
    logic [AW-1:0] track_len = AW'(100);
    logic          track_change = 1'b0;
    logic [7:0]    wr_byte = 8'h00;
    logic          dirty_clr = 1'b0;
    logic [7:0]    rd_byte;
    logic          byte_ready;
    logic          sync;
    logic          dirty;

    iecdrv_gcr_stream_if #(.ADDRWIDTH(AW)) mem_if ();

    iecdrv_gcr_stream #(.ADDRWIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .mtr          (mtr),
        .mode         (mode),
        .speed_zone   (speed_zone),
        .track_len    (track_len),
        .track_change (track_change),
        .wr_byte      (wr_byte),
        .dirty_clr    (dirty_clr),
        .mem          (mem_if),
        .rd_byte      (rd_byte),
        .byte_ready   (byte_ready),
        .sync         (sync),
        .dirty        (dirty)
    );

    always #5 clk = ~clk;

    // Track RAM with two-clock read latency.
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rd_pipe;
    always @(posedge clk) begin
        rd_pipe        <= mem[mem_if.mem_addr];
        mem_if.mem_din <= rd_pipe;
        if (mem_if.mem_we) mem[mem_if.mem_addr] <= mem_if.mem_dout;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [AW-1:0]   addr_sb[$];
    logic [7:0]      rd_sb[$];
    logic [AW+7:0]   wr_sb[$];

    typedef struct {
        logic [1:0] zone;
        int         len;
        int         interval;
    } per_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        track_change = 1'b0;
        dirty_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_addr_change(input int budget, output int t, output bit ok);
        logic [AW-1:0] old;
        old = mem_if.mem_addr;
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (mem_if.mem_addr !== old) begin
                ok = 1'b1;
                t = cyc;
            end
        end
    endtask

    task automatic wait_addr_eq(input logic [AW-1:0] val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (mem_if.mem_addr === val) ok = 1'b1;
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_we(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (mem_if.mem_we === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic count_we(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mem_if.mem_we !== 1'b0) n++;
        end
    endtask

    initial begin
        per_vec_t pv[5];
        int t, t_prev, t0, n;
        bit ok;
        logic [AW-1:0] ea;
        logic [AW+7:0] ew;
        int t_run, t_rise, t_fall, t_rdy1, t_rdy2, n_rdy;
        logic prev_sync;

        pv[0] = '{2'd0, 100, 512};
        pv[1] = '{2'd1, 100, 480};
        pv[2] = '{2'd2, 100, 448};
        pv[3] = '{2'd3, 4, 416};
        pv[4] = '{2'd3, 1, 0};

        clear_mem();

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst mem_addr", mem_if.mem_addr, 0);
        check("rst mem_we", mem_if.mem_we, 0);
        check("rst mem_dout", mem_if.mem_dout, 0);
        check("rst rd_byte", rd_byte, 0);
        check("rst byte_ready", byte_ready, 0);
        check("rst sync", sync, 0);
        check("rst dirty", dirty, 0);

        // Bit rate per zone and address wrap.
        for (int i = 0; i < 5; i++) begin
            speed_zone = pv[i].zone;
            track_len = AW'(pv[i].len);
            mode = 1'b1;
            mtr = 1'b1;
            do_reset();
            if (pv[i].interval == 0) begin
                n = 0;
                for (int k = 0; k < 600; k++) begin
                    @(negedge clk);
                    if (mem_if.mem_addr !== '0) n++;
                end
                check("len1 no ticks", n, 0);
            end else begin
                addr_sb.delete();
                for (int k = 1; k <= 4; k++) addr_sb.push_back(AW'(k % pv[i].len));
                wait_addr_change(20, t_prev, ok);
                check("load done", ok, 1);
                ea = addr_sb.pop_front();
                check("load addr", mem_if.mem_addr, ea);
                for (int k = 0; k < 3; k++) begin
                    wait_addr_change(pv[i].interval + 20, t, ok);
                    check("boundary seen", ok, 1);
                    check("byte interval", t - t_prev, pv[i].interval);
                    ea = addr_sb.pop_front();
                    check("boundary addr", mem_if.mem_addr, ea);
                    t_prev = t;
                end
            end
        end

        // Motor off freezes bit timing.
        speed_zone = 2'd3;
        track_len = AW'(100);
        do_reset();
        wait_addr_change(20, t0, ok);
        repeat (100) @(negedge clk);
        mtr = 1'b0;
        repeat (1000) @(negedge clk);
        check("mtr off pos", mem_if.mem_addr, 1);
        mtr = 1'b1;
        wait_addr_change(416 + 1000 + 20, t, ok);
        check("mtr resume seen", ok, 1);
        check("mtr resume time", t - t0, 416 + 1000);

        // Sync and framing over FF FF 52 55.
        mem[0] = 8'hFF;
        mem[1] = 8'hFF;
        mem[2] = 8'h52;
        mem[3] = 8'h55;
        track_len = AW'(4);
        rd_sb.delete();
        rd_sb.push_back(8'hFF);
        rd_sb.push_back(8'h52);
        rd_sb.push_back(8'h55);
        rd_sb.push_back(8'hFF);
        rd_sb.push_back(8'h52);
        rd_sb.push_back(8'h55);
        do_reset();
        t_run = -1; t_rise = -1; t_fall = -1; t_rdy1 = -1; t_rdy2 = -1; n_rdy = 0;
        prev_sync = 1'b0;
        for (int k = 0; k < 3500; k++) begin
            @(negedge clk);
            if (t_run < 0 && mem_if.mem_addr === AW'(1)) t_run = cyc;
            if (sync === 1'b1 && !prev_sync && t_rise < 0) t_rise = cyc;
            if (sync === 1'b0 && prev_sync && t_fall < 0) t_fall = cyc;
            prev_sync = sync;
            if (byte_ready === 1'b1) begin
                n_rdy++;
                if (n_rdy == 1) t_rdy1 = cyc;
                if (n_rdy == 2) t_rdy2 = cyc;
                if (rd_sb.size() > 0) begin
                    check("rd_byte", rd_byte, rd_sb.pop_front());
                end else begin
                    check("extra byte_ready", 1, 0);
                end
            end
        end
        check("rd bytes left", rd_sb.size(), 0);
        check("sync rise", t_rise - t_run, 10 * 52);
        check("sync fall", t_fall - t_run, 17 * 52);
        check("first ready", t_rdy1 - t_run, 8 * 52);
        check("0x52 ready", t_rdy2 - t_run, 24 * 52);

        // Single write at byte 5, mode switched mid-byte, dirty_clr coincident with write.
        clear_mem();
        track_len = AW'(100);
        mode = 1'b1;
        do_reset();
        wait_addr_eq(AW'(5), 7 * 416, ok);
        check("reach byte 4", ok, 1);
        mode = 1'b0;
        wr_byte = 8'hA5;
        wr_sb.push_back({AW'(5), 8'hA5});
        wait_ready(416 + 20, ok);
        check("write byte_ready", ok, 1);
        check("no early we", mem_if.mem_we, 0);
        check("dirty before", dirty, 0);
        mode = 1'b1;
        wr_byte = 8'h00;
        wait_we(416 + 20, ok);
        check("we seen", ok, 1);
        ew = wr_sb.pop_front();
        check("we addr", mem_if.mem_addr, ew[AW+7:8]);
        check("we data", mem_if.mem_dout, ew[7:0]);
        dirty_clr = 1'b1;
        @(negedge clk);
        check("we one cycle", mem_if.mem_we, 0);
        check("addr restored", mem_if.mem_addr, 7);
        check("dirty set wins", dirty, 1);
        @(negedge clk);
        check("dirty cleared", dirty, 0);
        dirty_clr = 1'b0;
        check("ram written", mem[5], 8'hA5);
        count_we(900, n);
        check("no further we", n, 0);

        // Reset at bit 4 of a write byte.
        mode = 1'b0;
        wr_byte = 8'h3C;
        do_reset();
        wait_addr_change(20, t0, ok);
        check("wr load ready", byte_ready, 1);
        count_we(4 * 52 + 26, n);
        check("no we before rst", n, 0);
        reset = 1'b1;
        mode = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid rst mem_addr", mem_if.mem_addr, 0);
        check("mid rst mem_we", mem_if.mem_we, 0);
        check("mid rst mem_dout", mem_if.mem_dout, 0);
        check("mid rst rd_byte", rd_byte, 0);
        check("mid rst ready", byte_ready, 0);
        check("mid rst sync", sync, 0);
        check("mid rst dirty", dirty, 0);
        count_we(1000, n);
        check("no we after rst", n, 0);

        // Track change cancels a pending write and reloads the position.
        mode = 1'b0;
        wr_byte = 8'h77;
        do_reset();
        wait_addr_change(20, t0, ok);
        repeat (200) @(negedge clk);
        mode = 1'b1;
        track_change = 1'b1;
        @(negedge clk);
        track_change = 1'b0;
        check("reload addr", mem_if.mem_addr, 0);
        count_we(1200, n);
        check("write cancelled", n, 0);
        wait_addr_eq(AW'(10), 11 * 416, ok);
        check("reach byte 9", ok, 1);
        track_len = AW'(5);
        track_change = 1'b1;
        @(negedge clk);
        track_change = 1'b0;
        check("shrink addr", mem_if.mem_addr, 0);
        repeat (3) @(negedge clk);
        check("shrink next", mem_if.mem_addr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/iecdrv_gcr_stream.md
IECDRV_GCR_STREAM -- requirements
Module: iecdrv_gcr_stream

Interface
REQ-001 Parameter ADDRWIDTH, default 13, byte-address width of the track memory.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ce  in  1  16 MHz drive-clock enable; cell timing advances only when ce=1.
REQ-005 mtr  in  1  spindle motor on; 0 freezes bit timing and position.
REQ-006 mode  in  1  1=read, 0=write; sampled only at memory-byte boundaries.
REQ-007 speed_zone  in  2  density zone 0..3.
REQ-008 track_len  in  ADDRWIDTH  track length in bytes.
REQ-009 track_change  in  1  one-cycle pulse after head step; forces reload.
REQ-010 wr_byte  in  8  byte to write (write mode).
REQ-011 dirty_clr  in  1  clears dirty.
REQ-012 mem_addr  out  ADDRWIDTH  track-memory address.
REQ-013 mem_din  in  8  track-memory read data, valid 2 clk after mem_addr.
REQ-014 mem_dout  out  8  track-memory write data.
REQ-015 mem_we  out  1  track-memory write strobe.
REQ-016 rd_byte  out  8  last framed GCR byte (read mode).
REQ-017 byte_ready  out  1  one-cycle pulse per framed/consumed byte.
REQ-018 sync  out  1  level, high while >=10 consecutive 1 bits seen.
REQ-019 dirty  out  1  track memory modified since last clear.

Function
REQ-020 FSM states LOAD0, LOAD1, LOAD2, RUN; LOAD0 drives mem_addr=byte_addr, LOAD1 waits, LOAD2 captures mem_din into cur_byte and drives mem_addr=next address, then RUN.
REQ-021 LOAD0 entered from reset and from any state on track_change; if byte_addr >= track_len, byte_addr becomes 0 on entry.
REQ-022 Bit tick: in RUN with mtr=1 and track_len>=2, cell counter increments on ce; at count (16-speed_zone)*4-1 with ce=1 a bit tick occurs and counter returns to 0 (periods 64/60/56/52 ce).
REQ-023 Cell counter held (not cleared) when mtr=0, track_len<2, or not in RUN; no bit ticks.
REQ-024 Bits consumed MSB first from cur_byte; bit_idx 0..7 advances per tick.
REQ-025 Tick at bit_idx=7 is a byte boundary: cur_byte<=mem_din, byte_addr<=next address, mem_addr<=following address, mode latched.
REQ-026 Next address = byte_addr+1, or 0 when byte_addr+1 >= track_len (wrap).
REQ-027 Read: ones counter increments on each 1 bit (saturating at 15), clears on 0 bit; sync=1 when counter>=10 at tick, sync=0 on first 0 bit.
REQ-028 Read framing independent of memory alignment: shift register shifts each bit; frame counter held at 0 while sync=1; after 8 bits, rd_byte<=shift value, byte_ready pulses one cycle, counter restarts.
REQ-029 Write: at byte boundary entering a write byte, wr_byte latched into wr_shift and byte_ready pulses; no sync/rd_byte updates.
REQ-030 Write: at that byte's bit_idx=7 tick, one-cycle mem_we=1, mem_addr=byte_addr, mem_dout=wr_shift; the cycle after, mem_addr returns to next address and the boundary read is taken 2 clk later (deadline met since bit period >=52 clk).
REQ-031 dirty set on any mem_we cycle; dirty_clr clears; coincident set and clear -> dirty=1.
REQ-032 mode change mid-byte takes effect at next byte boundary only.
REQ-033 track_change during a pending write cancels it; no mem_we.

Reset
REQ-034 On reset: state LOAD0, byte_addr=0, bit_idx=0, cell counter=0, ones counter=0, frame counter=0, mem_addr=0, mem_we=0, mem_dout=0, rd_byte=0x00, byte_ready=0, sync=0, dirty=0.
REQ-035 Reset during any state or mid-write aborts activity; no mem_we in the reset cycle or after until a new write byte completes.

Verification
REQ-036 ce=1 every clk, mtr=1, zone 3 -> bit ticks every 52 clk; zone 0 -> every 64; mtr=0 -> no ticks, position unchanged.
REQ-037 Memory FF FF 52 55, read mode -> sync rises on 10th 1 bit, falls on first 0 bit of 0x52, byte_ready 8 bits later with rd_byte=0x52.
REQ-038 track_len=4 -> byte boundary addresses 0,1,2,3,0,1; track_len=1 -> no ticks.
REQ-039 Write mode, byte_addr=5, wr_byte=0xA5 -> single mem_we cycle with mem_addr=5, mem_dout=0xA5; dirty=1.
REQ-040 Reset asserted at bit_idx=4 of a write byte -> no mem_we; all outputs at REQ-034 values next cycle.
REQ-041 dirty_clr asserted in same cycle as mem_we -> dirty=1; dirty_clr next cycle -> dirty=0.
